// File: rtl/display_pkg.sv
// display_pkg
//   Shared TMDS definitions for the DVI receive path.
//   - TMDS_W            : width of one TMDS symbol
//   - TMDS_CTRL_00..11  : control-period tokens, indexed by {C1,C0}
//   - tmds_rx_state_t   : word-alignment state of a channel receiver
package display_pkg;

  localparam int TMDS_W = 10;

  localparam logic [TMDS_W-1:0] TMDS_CTRL_00 = 10'h354;
  localparam logic [TMDS_W-1:0] TMDS_CTRL_01 = 10'h0AB;
  localparam logic [TMDS_W-1:0] TMDS_CTRL_10 = 10'h154;
  localparam logic [TMDS_W-1:0] TMDS_CTRL_11 = 10'h2AB;

  typedef enum logic {
    SEARCH = 1'b0,
    LOCKED = 1'b1
  } tmds_rx_state_t;

endpackage

// File: rtl/tmds_word_decode.sv
// tmds_word_decode
//   Purely combinational decode of one aligned TMDS symbol.
//   Ports:
//     i_word     [9:0]  aligned TMDS symbol (bit 0 earliest)
//     o_data     [7:0]  decoded pixel byte (meaningful for data symbols)
//     o_is_token        symbol is one of the four control tokens
//     o_c1, o_c0        control bits carried by the token (0 otherwise)
module tmds_word_decode
  import display_pkg::*;
(
  input  logic [TMDS_W-1:0] i_word,
  output logic [7:0]        o_data,
  output logic              o_is_token,
  output logic              o_c1,
  output logic              o_c0
);

  // Undo the DC-balance inversion first, then the transition-minimising chain.
  logic [7:0] w_q;
  assign w_q = i_word[9] ? ~i_word[7:0] : i_word[7:0];

  assign o_data[0] = w_q[0];

  genvar gi;
  for (gi = 1; gi < 8; gi++) begin : g_chain
    // bit 8 selects XOR (1) or XNOR (0) encoding
    assign o_data[gi] = i_word[8] ? (w_q[gi] ^ w_q[gi-1]) : ~(w_q[gi] ^ w_q[gi-1]);
  end

  always_comb begin
    o_is_token = 1'b1;
    o_c1       = 1'b0;
    o_c0       = 1'b0;
    case (i_word)
      TMDS_CTRL_00: ;
      TMDS_CTRL_01: o_c0 = 1'b1;
      TMDS_CTRL_10: o_c1 = 1'b1;
      TMDS_CTRL_11: begin
        o_c1 = 1'b1;
        o_c0 = 1'b1;
      end
      default: o_is_token = 1'b0;
    endcase
  end

endmodule

// File: rtl/tmds_channel_rx.sv
// tmds_channel_rx
//   One TMDS channel receiver: word alignment by control-token runs,
//   then decode to pixel byte / C0 / C1 / DE.
//   Ports:
//     clk_i        pixel clock
//     rst_ni       asynchronous active-low reset
//     raw_i  [9:0] deserialized word, arbitrary alignment, bit 0 earliest
//     data_o [7:0] decoded pixel byte
//     c0_o, c1_o   control bits (hsync/vsync on blue)
//     de_o         data enable
//     locked_o     word alignment established
//   Optional (macro TMDS_RX_DBG_EN):
//     offset_o    [3:0] current slip offset
//     lock_loss_o [7:0] saturating count of lock losses
module tmds_channel_rx
  import display_pkg::*;
#(
  parameter int TOKEN_RUN      = 8,
  parameter int SEARCH_TIMEOUT = 1024,
  parameter int LOCK_TIMEOUT   = 4096
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic [TMDS_W-1:0] raw_i,
  output logic [7:0]        data_o,
  output logic              c0_o,
  output logic              c1_o,
  output logic              de_o,
  output logic              locked_o
`ifdef TMDS_RX_DBG_EN
  ,
  output logic [3:0]        offset_o,
  output logic [7:0]        lock_loss_o
`endif
);

  localparam int RUN_W = $clog2(TOKEN_RUN) + 1;
  localparam int TMO_W = ((SEARCH_TIMEOUT > LOCK_TIMEOUT) ?
                          $clog2(SEARCH_TIMEOUT) : $clog2(LOCK_TIMEOUT)) + 1;

  tmds_rx_state_t    r_state;
  logic [TMDS_W-1:0] r_raw_q;
  logic [TMDS_W-1:0] r_word_q;
  logic [3:0]        r_offset;
  logic [RUN_W-1:0]  r_run_cnt;
  logic [TMO_W-1:0]  r_tmo_cnt;
  logic [7:0]        r_data;
  logic              r_c0;
  logic              r_c1;
  logic              r_de;

  // Two consecutive words side by side; the aligned symbol may straddle them.
  logic [2*TMDS_W-1:0] w_cat;
  logic [TMDS_W-1:0]   w_window;
  assign w_cat    = {raw_i, r_raw_q};
  assign w_window = w_cat[r_offset +: TMDS_W];

  logic [7:0] w_d;
  logic       w_is_token;
  logic       w_c1;
  logic       w_c0;

  tmds_word_decode u_decode (
    .i_word     (r_word_q),
    .o_data     (w_d),
    .o_is_token (w_is_token),
    .o_c1       (w_c1),
    .o_c0       (w_c0)
  );

  // Lock wins over a coincident search timeout, so it is tested first.
  logic w_lock_go;
  logic w_slip;
  logic w_lock_drop;
  logic w_out_en;
  assign w_lock_go   = (r_state == SEARCH) && (r_run_cnt == RUN_W'(TOKEN_RUN));
  assign w_slip      = (r_state == SEARCH) && !w_lock_go &&
                       (r_tmo_cnt == TMO_W'(SEARCH_TIMEOUT - 1));
  assign w_lock_drop = (r_state == LOCKED) && (r_tmo_cnt == TMO_W'(LOCK_TIMEOUT - 1));
  // Outputs follow the state being entered so they switch on the same edge as locked_o.
  assign w_out_en    = w_lock_go || ((r_state == LOCKED) && !w_lock_drop);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state   <= SEARCH;
      r_raw_q   <= '0;
      r_word_q  <= '0;
      r_offset  <= '0;
      r_run_cnt <= '0;
      r_tmo_cnt <= '0;
      r_data    <= '0;
      r_c0      <= 1'b0;
      r_c1      <= 1'b0;
      r_de      <= 1'b0;
    end else begin
      r_raw_q  <= raw_i;
      r_word_q <= w_window;

      case (r_state)
        SEARCH: begin
          if (w_lock_go) begin
            r_state   <= LOCKED;
            r_run_cnt <= '0;
            r_tmo_cnt <= '0;
          end else if (w_slip) begin
            r_offset  <= (r_offset == 4'd9) ? 4'd0 : r_offset + 4'd1;
            r_run_cnt <= '0;
            r_tmo_cnt <= '0;
          end else begin
            r_run_cnt <= w_is_token ? r_run_cnt + RUN_W'(1) : '0;
            r_tmo_cnt <= r_tmo_cnt + TMO_W'(1);
          end
        end
        LOCKED: begin
          if (w_lock_drop) begin
            r_state   <= SEARCH;
            r_run_cnt <= '0;
            r_tmo_cnt <= '0;
          end else begin
            r_tmo_cnt <= w_is_token ? '0 : r_tmo_cnt + TMO_W'(1);
          end
        end
        default: r_state <= SEARCH;
      endcase

      if (!w_out_en) begin
        r_data <= '0;
        r_c0   <= 1'b0;
        r_c1   <= 1'b0;
        r_de   <= 1'b0;
      end else if (w_is_token) begin
        r_de <= 1'b0;
        r_c0 <= w_c0;
        r_c1 <= w_c1;
      end else begin
        r_de   <= 1'b1;
        r_data <= w_d;
      end
    end
  end

  assign data_o   = r_data;
  assign c0_o     = r_c0;
  assign c1_o     = r_c1;
  assign de_o     = r_de;
  assign locked_o = (r_state == LOCKED);

`ifdef TMDS_RX_DBG_EN
  logic [7:0] r_lock_loss;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_lock_loss <= '0;
    end else if (w_lock_drop && (r_lock_loss != 8'hFF)) begin
      r_lock_loss <= r_lock_loss + 8'd1;
    end
  end

  assign offset_o    = r_offset;
  assign lock_loss_o = r_lock_loss;
`endif

endmodule
